// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera-side I2C register responder.
// Holds the protocol state enumeration and the bus header helpers.
package cam_i2c_pkg;

    localparam logic [6:0] CAM_DEV_ADDR = 7'h5C;
    localparam logic       I2C_WR       = 1'b0;
    localparam logic       I2C_RD       = 1'b1;
    localparam logic [3:0] BYTE_BITS    = 4'd8;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WR_HI     = 4'd5,
        WR_HI_ACK = 4'd6,
        WR_LO     = 4'd7,
        WR_LO_ACK = 4'd8,
        RD_HI     = 4'd9,
        RD_HI_ACK = 4'd10,
        RD_LO     = 4'd11,
        RD_LO_ACK = 4'd12,
        WAIT_STOP = 4'd13
    } i2c_state_e;

    // True when the 7-bit address field of a header byte selects this target.
    function automatic logic hdr_match(input logic [7:0] hdr, input logic [6:0] dev);
        return (hdr[7:1] == dev);
    endfunction

endpackage

// File: rtl/i2c_edge_sync.sv
// Brings the asynchronous SCL/SDA pads into the sysclk domain and derives
// clock edges plus START/STOP conditions from the synchronized levels.
module i2c_edge_sync (
    input  logic sysclk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;
    logic       scl_s;
    logic       sda_s;

    // Two-stage synchronizers plus one history flop per line; idle bus level is high.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    assign scl_s = scl_sync_r[1];
    assign sda_s = sda_sync_r[1];

    // SDA only counts as START/STOP when SCL was high on both sides of its edge.
    assign scl_rise  = scl_s & ~scl_prev_r;
    assign scl_fall  = ~scl_s & scl_prev_r;
    assign start_det = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_det  = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign sda_bit   = sda_s;

endmodule

// File: rtl/cam_i2c_responder.sv
// I2C target exposing a 16-bit register file through an 8-bit auto-incrementing
// pointer; writes and reads are handed to the host as single-cycle strobes.
module cam_i2c_responder
    import cam_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CAM_DEV_ADDR
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy
);

    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_det_s;
    logic        stop_det_s;
    logic        sda_bit_s;

    i2c_state_e  state_r;
    logic [3:0]  bit_cnt_r;
    logic [7:0]  rx_shift_r;
    logic [15:0] tx_shift_r;
    logic [7:0]  ptr_r;
    logic [7:0]  hi_byte_r;
    logic        rw_r;
    logic        mack_r;
    logic        load_pend_r;

    i2c_edge_sync u_sync (
        .sysclk    (sysclk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s),
        .sda_bit   (sda_bit_s)
    );

    // Protocol FSM: bits sampled on SCL rise, SDA drive and state changes on SCL fall.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            rx_shift_r  <= 8'h00;
            tx_shift_r  <= 16'h0000;
            ptr_r       <= 8'h00;
            hi_byte_r   <= 8'h00;
            rw_r        <= 1'b0;
            mack_r      <= 1'b1;
            load_pend_r <= 1'b0;
            sda_oe      <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 16'h0000;
            rd_en       <= 1'b0;
            rd_addr     <= 8'h00;
            busy        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;

            // Read data arrives the cycle after rd_en; put its MSB on the bus right away.
            if (load_pend_r) begin
                tx_shift_r  <= rd_data;
                sda_oe      <= ~rd_data[15];
                load_pend_r <= 1'b0;
            end

            if (start_det_s) begin
                state_r     <= ADDR;
                bit_cnt_r   <= 4'd0;
                sda_oe      <= 1'b0;
                load_pend_r <= 1'b0;
            end else if (stop_det_s) begin
                state_r     <= IDLE;
                bit_cnt_r   <= 4'd0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                load_pend_r <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ADDR, REG, WR_HI, WR_LO: begin
                        rx_shift_r <= {rx_shift_r[6:0], sda_bit_s};
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                    end
                    RD_HI, RD_LO: begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                    RD_LO_ACK: begin
                        mack_r <= sda_bit_s;
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ADDR: begin
                        if (bit_cnt_r == BYTE_BITS) begin
                            bit_cnt_r <= 4'd0;
                            if (hdr_match(rx_shift_r, DEV_ADDR)) begin
                                rw_r    <= rx_shift_r[0];
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                                state_r <= ADDR_ACK;
                            end else begin
                                busy    <= 1'b0;
                                state_r <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        sda_oe <= 1'b0;
                        if (rw_r == I2C_WR) begin
                            state_r <= REG;
                        end else begin
                            rd_en       <= 1'b1;
                            rd_addr     <= ptr_r;
                            load_pend_r <= 1'b1;
                            state_r     <= RD_HI;
                        end
                    end
                    REG: begin
                        if (bit_cnt_r == BYTE_BITS) begin
                            bit_cnt_r <= 4'd0;
                            ptr_r     <= rx_shift_r;
                            sda_oe    <= 1'b1;
                            state_r   <= REG_ACK;
                        end
                    end
                    REG_ACK: begin
                        sda_oe  <= 1'b0;
                        state_r <= WR_HI;
                    end
                    WR_HI: begin
                        if (bit_cnt_r == BYTE_BITS) begin
                            bit_cnt_r <= 4'd0;
                            hi_byte_r <= rx_shift_r;
                            sda_oe    <= 1'b1;
                            state_r   <= WR_HI_ACK;
                        end
                    end
                    WR_HI_ACK: begin
                        sda_oe  <= 1'b0;
                        state_r <= WR_LO;
                    end
                    WR_LO: begin
                        if (bit_cnt_r == BYTE_BITS) begin
                            bit_cnt_r <= 4'd0;
                            sda_oe    <= 1'b1;
                            state_r   <= WR_LO_ACK;
                        end
                    end
                    WR_LO_ACK: begin
                        // rx_shift still holds the low byte: ACK bits do not shift.
                        sda_oe  <= 1'b0;
                        wr_en   <= 1'b1;
                        wr_addr <= ptr_r;
                        wr_data <= {hi_byte_r, rx_shift_r};
                        ptr_r   <= ptr_r + 8'd1;
                        state_r <= WR_HI;
                    end
                    RD_HI, RD_LO: begin
                        tx_shift_r <= {tx_shift_r[14:0], 1'b0};
                        if (bit_cnt_r == BYTE_BITS) begin
                            bit_cnt_r <= 4'd0;
                            sda_oe    <= 1'b0;
                            state_r   <= (state_r == RD_HI) ? RD_HI_ACK : RD_LO_ACK;
                        end else begin
                            sda_oe <= ~tx_shift_r[14];
                        end
                    end
                    RD_HI_ACK: begin
                        sda_oe  <= ~tx_shift_r[15];
                        state_r <= RD_LO;
                    end
                    RD_LO_ACK: begin
                        sda_oe <= 1'b0;
                        if (mack_r == 1'b0) begin
                            ptr_r       <= ptr_r + 8'd1;
                            rd_en       <= 1'b1;
                            rd_addr     <= ptr_r + 8'd1;
                            load_pend_r <= 1'b1;
                            state_r     <= RD_HI;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= WAIT_STOP;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
